// File: rtl/reg_file_onehot_wr.sv
// ---------------------------------------------------------------------------
// reg_file_onehot_wr
//   General-purpose register file of the single-cycle core. The write port is
//   addressed by the one-hot output of the upstream 4-to-16 decoder. Two
//   independent combinational read ports feed the operand stage. Malformed
//   (multi-hot) write selects raise a sticky status flag.
//
// Ports
//   clk        in   1       system clock, rising edge
//   rst        in   1       asynchronous, active-high reset
//   we         in   1       write enable
//   wr_sel     in   NREGS   one-hot write select; bit k selects R[k]
//   wr_data    in   DATA_W  write data
//   rd_addr_a  in   4       read port A register index
//   rd_addr_b  in   4       read port B register index
//   rd_data_a  out  DATA_W  read port A data
//   rd_data_b  out  DATA_W  read port B data
//   wr_count   out  8       committed writes, saturating at 8'hFF
//   sel_err    out  1       sticky: a write was attempted with a multi-hot wr_sel
// ---------------------------------------------------------------------------
module reg_file_onehot_wr #(
  parameter int DATA_W  = 32,
  parameter int NREGS   = 16,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [NREGS-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_addr_a,
  input  logic [3:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [7:0]        wr_count,
  output logic              sel_err
);

  logic [DATA_W-1:0] regs [NREGS];

  logic       sel_zero;
  logic       sel_onehot;
  logic       sel_multi;
  logic [3:0] wr_idx;
  logic       commit;

  // A vector is one-hot when it is nonzero and clearing its lowest set bit
  // leaves nothing behind.
  assign sel_zero   = (wr_sel == '0);
  assign sel_onehot = !sel_zero && ((wr_sel & (wr_sel - 1'b1)) == '0);
  assign sel_multi  = !sel_zero && !sel_onehot;

  // Encode the selected index; only meaningful when sel_onehot is true.
  // NOTE: wr_idx gets a default before the loop so no latch is inferred when
  // no bit is set.
  always_comb begin
    wr_idx = '0;
    for (int k = 0; k < NREGS; k++) begin
      if (wr_sel[k]) wr_idx = 4'(k);
    end
  end

  // A write commits only for a clean one-hot select, and never to a
  // hardwired R0.
  assign commit = we && sel_onehot && !(ZERO_R0 && (wr_idx == 4'd0));

  // NOTE: the register array is reset on purpose: reads must show 0
  // immediately after rst, so these are real flops, not an inferred RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      wr_count <= '0;
      sel_err  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge
      // values, regardless of statement order.
      if (commit) begin
        regs[wr_idx] <= wr_data;
        if (wr_count != 8'hFF) wr_count <= wr_count + 8'd1;
      end
      if (we && sel_multi) sel_err <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [3:0] addr);
    if (ZERO_R0 && (addr == 4'd0))
      return '0;
    else if (BYPASS && commit && (addr == wr_idx))
      return wr_data;
    else
      return regs[addr];
  endfunction

  assign rd_data_a = read_port(rd_addr_a);
  assign rd_data_b = read_port(rd_addr_b);

endmodule

// File: tb/tb_reg_file_onehot_wr.sv
// ---------------------------------------------------------------------------
// tb_reg_file_onehot_wr
//   Drives two instances side by side from the same stimulus:
//     dut_a : default parameters (ZERO_R0=1, BYPASS=0)
//     dut_b : ZERO_R0=0, BYPASS=1
//   A behavioural model (plain arrays and counters) predicts reads, the
//   write counter and the error flag for each instance.
// ---------------------------------------------------------------------------
module tb_reg_file_onehot_wr;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        we = 1'b0;
  logic [15:0] wr_sel = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  rd_addr_a = '0;
  logic [3:0]  rd_addr_b = '0;

  logic [31:0] rd_data_a_a, rd_data_b_a, rd_data_a_b, rd_data_b_b;
  logic [7:0]  wr_count_a, wr_count_b;
  logic        sel_err_a, sel_err_b;

  reg_file_onehot_wr dut_a (
    .clk(clk), .rst(rst), .we(we), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a_a), .rd_data_b(rd_data_b_a),
    .wr_count(wr_count_a), .sel_err(sel_err_a)
  );

  reg_file_onehot_wr #(.ZERO_R0(1'b0), .BYPASS(1'b1)) dut_b (
    .clk(clk), .rst(rst), .we(we), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a_b), .rd_data_b(rd_data_b_b),
    .wr_count(wr_count_b), .sel_err(sel_err_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  int          cnt_a, cnt_b;
  bit          err_a, err_b;

  function automatic int sel_index(input logic [15:0] s);
    int r = -1;
    for (int k = 0; k < 16; k++) if (s[k]) r = k;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 16; k++) begin
      mem_a[k] = '0;
      mem_b[k] = '0;
    end
    cnt_a = 0; cnt_b = 0; err_a = 0; err_b = 0;
  endtask

  // Applies the write rules for one rising edge using the current inputs.
  task automatic model_edge();
    int n;
    int k;
    if (!we) return;
    n = $countones(wr_sel);
    if (n == 1) begin
      k = sel_index(wr_sel);
      if (k != 0) begin
        mem_a[k] = wr_data;
        if (cnt_a < 255) cnt_a++;
      end
      mem_b[k] = wr_data;
      if (cnt_b < 255) cnt_b++;
    end else if (n > 1) begin
      err_a = 1;
      err_b = 1;
    end
  endtask

  function automatic logic [31:0] exp_rd_a(input logic [3:0] addr);
    if (addr == 4'd0) return 32'h0;
    return mem_a[addr];
  endfunction

  // Instance B bypasses the write data on a same-cycle read of the target.
  function automatic logic [31:0] exp_rd_b(input logic [3:0] addr);
    if (we && $countones(wr_sel) == 1 && sel_index(wr_sel) == int'(addr))
      return wr_data;
    return mem_b[addr];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, ".a_rda"}, rd_data_a_a, exp_rd_a(rd_addr_a));
    check({tag, ".a_rdb"}, rd_data_b_a, exp_rd_a(rd_addr_b));
    check({tag, ".b_rda"}, rd_data_a_b, exp_rd_b(rd_addr_a));
    check({tag, ".b_rdb"}, rd_data_b_b, exp_rd_b(rd_addr_b));
  endtask

  task automatic check_status(input string tag);
    check({tag, ".a_cnt"}, {24'h0, wr_count_a}, cnt_a);
    check({tag, ".b_cnt"}, {24'h0, wr_count_b}, cnt_b);
    check({tag, ".a_err"}, {31'h0, sel_err_a}, {31'h0, err_a});
    check({tag, ".b_err"}, {31'h0, sel_err_b}, {31'h0, err_b});
  endtask

  // Called just after a rising edge: drive, check combinational reads before
  // the next edge, then check state after it.
  task automatic do_cycle(input string tag, input logic w, input logic [15:0] s,
                          input logic [31:0] d, input logic [3:0] ra, input logic [3:0] rb);
    we = w; wr_sel = s; wr_data = d; rd_addr_a = ra; rd_addr_b = rb;
    #2;
    check_reads({tag, ".pre"});
    @(posedge clk);
    model_edge();
    #1;
    check_reads({tag, ".post"});
    check_status(tag);
  endtask

  // Mid-cycle asynchronous reset, away from any clock edge.
  task automatic pulse_reset(input string tag);
    we = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < 16; k++) begin
      rd_addr_a = 4'(k);
      rd_addr_b = 4'(15 - k);
      #0.1;
      check_reads({tag, ".rst"});
    end
    check_status({tag, ".rst"});
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] rand_sel();
    int r = $urandom_range(0, 9);
    int i, j;
    if (r == 0) return 16'h0;
    if (r == 1) begin
      i = $urandom_range(0, 15);
      j = (i + $urandom_range(1, 15)) % 16;
      return (16'h1 << i) | (16'h1 << j);
    end
    return 16'h1 << $urandom_range(0, 15);
  endfunction

  initial begin
    model_reset();
    #2;
    check_status("init_rst");
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill R0..R15 with nonzero data, then reset asynchronously mid-cycle.
    for (int k = 0; k < 16; k++)
      do_cycle("fill", 1'b1, 16'h1 << k, 32'h1000_0000 | 32'($urandom_range(1, 65535)), 4'(k), 4'(k));
    pulse_reset("reset1");

    // Basic write/read.
    do_cycle("basic_wr", 1'b1, 16'h0020, 32'hDEADBEEF, 4'd0, 4'd0);
    do_cycle("basic_rd", 1'b0, 16'h0020, 32'h0, 4'd5, 4'd5);
    check("basic_val", rd_data_a_a, 32'hDEADBEEF);
    check("basic_cnt", {24'h0, wr_count_a}, 32'd1);

    // R0 write: dropped on A, ordinary on B.
    do_cycle("r0_wr", 1'b1, 16'h0001, 32'h12345678, 4'd5, 4'd0);
    check("r0_rdb", rd_data_b_a, 32'h0);
    check("r0_cnt", {24'h0, wr_count_a}, 32'd1);

    // Zero select and we=0 with a junk select: no change, no error.
    do_cycle("sel_zero", 1'b1, 16'h0000, 32'h55, 4'd5, 4'd0);
    do_cycle("we_low", 1'b0, 16'h0018, 32'h66, 4'd3, 4'd4);

    // Malformed select leaves R3/R4 intact and latches sel_err.
    do_cycle("r3", 1'b1, 16'h0008, 32'hAA, 4'd3, 4'd4);
    do_cycle("r4", 1'b1, 16'h0010, 32'hBB, 4'd3, 4'd4);
    do_cycle("multi", 1'b1, 16'h0018, 32'hFF, 4'd3, 4'd4);
    check("multi_r3", rd_data_a_a, 32'hAA);
    check("multi_r4", rd_data_b_a, 32'hBB);
    check("multi_err", {31'h0, sel_err_a}, 32'd1);
    for (int i = 0; i < 3; i++)
      do_cycle("sticky", 1'b1, 16'h0004, 32'(i + 7), 4'd2, 4'd3);
    check("sticky_err", {31'h0, sel_err_a}, 32'd1);
    pulse_reset("reset2");

    // Same-cycle read of the write target.
    do_cycle("r7_init", 1'b1, 16'h0080, 32'h1, 4'd7, 4'd7);
    we = 1'b1; wr_sel = 16'h0080; wr_data = 32'h2; rd_addr_a = 4'd7; rd_addr_b = 4'd7;
    #2;
    check("byp0_pre", rd_data_a_a, 32'h1);
    check("byp1_pre", rd_data_a_b, 32'h2);
    @(posedge clk);
    model_edge();
    #1;
    check("byp0_post", rd_data_a_a, 32'h2);
    check_status("r7");

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      if (i % 130 == 129) pulse_reset("rand_rst");
      do_cycle("rand", 1'($urandom_range(0, 3) != 0), rand_sel(), $urandom(),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Counter saturation.
    pulse_reset("reset3");
    for (int i = 0; i < 300; i++)
      do_cycle("sat", 1'b1, 16'h0200, 32'(i), 4'd9, 4'd0);
    check("sat_cnt_a", {24'h0, wr_count_a}, 32'hFF);
    check("sat_cnt_b", {24'h0, wr_count_b}, 32'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1);
  end

endmodule
